// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// MMIO register offsets and the store lane helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  // Byte offsets of the registers inside the 16-byte MMIO window
  localparam logic [3:0] MMIO_GPIO     = 4'h0;
  localparam logic [3:0] MMIO_MTIME    = 4'h4;
  localparam logic [3:0] MMIO_MTIMECMP = 4'h8;
  localparam logic [3:0] MMIO_TOHOST   = 4'hC;

  // Byte-lane enables for a store of the given size at the given byte offset
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lo;
      SIZE_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Copy the low store bits into every lane so any enabled lane sees them
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SIZE_BYTE: rep = {4{data[7:0]}};
      SIZE_HALF: rep = {2{data[15:0]}};
      default:   rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Byte-enabled single-port data RAM, synchronous write and registered read.
// Each byte lane is its own array so the tools map it onto block RAM lanes.
module riscv_dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q;

      // Lane write when enabled; lane read register loads only on an accepted read
      always_ff @(posedge clock) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          q <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = q;
    end
  endgenerate

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: address decode, RAM, MMIO registers (GPIO, timer,
// test-exit mailbox) and a sticky first-error capture.
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic        dmem_wen_i,
  input  logic        dmem_ren_i,
  input  logic [1:0]  dmem_size_i,
  output logic [31:0] dmem_rdata_o,
  output logic [31:0] gpio_o,
  output logic        timer_irq_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic        size_word;
  logic        size_half;
  logic        misaligned;
  logic        ram_hit;
  logic        mmio_hit;
  logic        unmapped;
  logic        access;
  logic        err_event;
  logic        do_write;
  logic        do_read;
  logic        ram_we;
  logic        ram_re;
  logic        mmio_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;
  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic        rdata_from_ram;
  logic [31:0] side_rdata;

  // Size 11 behaves as a word access
  assign size_word = dmem_size_i[1];
  assign size_half = (dmem_size_i == SIZE_HALF);

  assign misaligned = (size_half && dmem_addr_i[0]) || (size_word && (dmem_addr_i[1:0] != 2'b00));
  assign ram_hit    = ({1'b0, dmem_addr_i} < RAM_BYTES);
  assign mmio_hit   = !ram_hit && (dmem_addr_i[31:4] == MMIO_BASE[31:4]);
  assign unmapped   = !ram_hit && !mmio_hit;
  assign access     = dmem_wen_i || dmem_ren_i;

  assign err_event = (access && (misaligned || unmapped || (mmio_hit && !size_word)))
                   || (dmem_wen_i && dmem_ren_i);

  // A write wins over a simultaneous read; misaligned accesses do nothing
  assign do_write = dmem_wen_i && !misaligned;
  assign do_read  = dmem_ren_i && !dmem_wen_i && !misaligned;

  // Gating with reset drops a RAM write that is in flight when reset asserts
  assign ram_we  = do_write && ram_hit && !reset;
  assign ram_re  = do_read && ram_hit && !reset;
  assign mmio_we = do_write && mmio_hit && size_word;

  assign ram_be    = lane_enable(dmem_size_i, dmem_addr_i[1:0]);
  assign ram_wdata = lane_replicate(dmem_size_i, dmem_wdata_i);

  riscv_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .be    (ram_be),
    .re    (ram_re),
    .addr  (dmem_addr_i[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // MMIO read mux; sub-word or unmapped reads yield zero, TOHOST reads as zero
  always_comb begin
    mmio_rdata = '0;
    if (mmio_hit && size_word) begin
      case (dmem_addr_i[3:0])
        MMIO_GPIO:     mmio_rdata = gpio_o;
        MMIO_MTIME:    mmio_rdata = mtime;
        MMIO_MTIMECMP: mmio_rdata = mtimecmp;
        default:       mmio_rdata = '0;
      endcase
    end
  end

  // Read-path select: RAM data already sits in the RAM read register, every
  // other source is captured here so the output holds until the next read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_from_ram <= 1'b0;
      side_rdata     <= '0;
    end else if (do_read) begin
      rdata_from_ram <= ram_hit;
      side_rdata     <= ram_hit ? '0 : mmio_rdata;
    end
  end

  assign dmem_rdata_o = rdata_from_ram ? ram_rdata : side_rdata;

  // GPIO, timer compare and mailbox registers; MTIME writes are dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpio_o         <= '0;
      mtimecmp       <= 32'hFFFF_FFFF;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= '0;
    end else begin
      tohost_valid_o <= mmio_we && (dmem_addr_i[3:0] == MMIO_TOHOST);
      if (mmio_we) begin
        case (dmem_addr_i[3:0])
          MMIO_GPIO:     gpio_o        <= dmem_wdata_i;
          MMIO_MTIMECMP: mtimecmp      <= dmem_wdata_i;
          MMIO_TOHOST:   tohost_data_o <= dmem_wdata_i;
          default:       ;
        endcase
      end
    end
  end

  // Free-running timer and registered compare against MTIMECMP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime       <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      mtime       <= mtime + 32'd1;
      timer_irq_o <= (mtime >= mtimecmp);
    end
  end

  // Capture only the first faulting address; sticky until reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (err_event && !err_o) begin
      err_o      <= 1'b1;
      err_addr_o <= dmem_addr_i;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl: read results go through a scoreboard
// queue, register outputs are checked with immediate assertions.
module tb_riscv_dmem_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        wen   = 1'b0;
  logic        ren   = 1'b0;
  logic [1:0]  size  = 2'b10;
  logic [31:0] rdata;
  logic [31:0] gpio;
  logic        timer_irq;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        err;
  logic [31:0] err_addr;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  riscv_dmem_ctrl #(
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (MB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dmem_addr_i    (addr),
    .dmem_wdata_i   (wdata),
    .dmem_wen_i     (wen),
    .dmem_ren_i     (ren),
    .dmem_size_i    (size),
    .dmem_rdata_o   (rdata),
    .gpio_o         (gpio),
    .timer_irq_o    (timer_irq),
    .tohost_valid_o (tohost_valid),
    .tohost_data_o  (tohost_data),
    .err_o          (err),
    .err_addr_o     (err_addr)
  );

  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // One bus cycle: drive at negedge, return at the next negedge with strobes cleared
  task automatic op(input logic w, input logic r, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] s);
    wen = w; ren = r; addr = a; wdata = d; size = s;
    @(negedge clock);
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    op(1'b1, 1'b0, a, d, s);
    $display("write addr=%h data=%h size=%0d", a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] s, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    op(1'b0, 1'b1, a, 32'h0, s);
    $display("read  addr=%h size=%0d rdata=%h", a, s, rdata);
    chk(tag, rdata, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_gpio", gpio, 32'h0);
    chk1("rst_irq", timer_irq, 1'b0);
    chk1("rst_tohost_valid", tohost_valid, 1'b0);
    chk("rst_tohost_data", tohost_data, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    reset = 1'b0;

    // Byte-store lane replication
    wr(32'h100, 32'h1122_3344, SIZE_WORD);
    wr(32'h102, 32'h0000_00AB, SIZE_BYTE);
    rd(32'h100, SIZE_WORD, 32'h11AB_3344, "sb_lane");

    // Half store into the upper lane
    wr(32'h104, 32'h1234_5678, SIZE_WORD);
    wr(32'h106, 32'h0000_BEEF, SIZE_HALF);
    rd(32'h104, SIZE_WORD, 32'hBEEF_5678, "sh_lane");
    rd(32'h101, SIZE_BYTE, 32'h11AB_3344, "lb_fullword");

    // MMIO registers
    wr(MB + 32'h0, 32'hCAFE_F00D, SIZE_WORD);
    chk("gpio_write", gpio, 32'hCAFE_F00D);
    rd(MB + 32'h0, SIZE_WORD, 32'hCAFE_F00D, "gpio_read");
    rd(MB + 32'h8, SIZE_WORD, 32'hFFFF_FFFF, "mtimecmp_reset");
    rd(MB + 32'hC, SIZE_WORD, 32'h0, "tohost_read");

    // Mailbox pulse
    wr(MB + 32'hC, 32'h1, SIZE_WORD);
    chk1("tohost_pulse", tohost_valid, 1'b1);
    chk("tohost_data", tohost_data, 32'h1);
    @(negedge clock);
    chk1("tohost_pulse_end", tohost_valid, 1'b0);
    chk("tohost_data_hold", tohost_data, 32'h1);
    chk1("no_err_yet", err, 1'b0);

    // Misaligned half load
    rd(32'h100, SIZE_WORD, 32'h11AB_3344, "pre_mis");
    rd(32'h103, SIZE_HALF, 32'h11AB_3344, "mis_hold");
    chk1("mis_err", err, 1'b1);
    chk("mis_err_addr", err_addr, 32'h103);
    rd(32'h2000_0000, SIZE_WORD, 32'h0, "unmapped_rd");
    chk("err_sticky", err_addr, 32'h103);

    // Reset with a write pending
    rd(32'h100, SIZE_WORD, 32'h11AB_3344, "pre_rst");
    wen = 1'b1; addr = 32'h100; wdata = 32'hDEAD_BEEF; size = SIZE_WORD;
    #2 reset = 1'b1;
    #1;
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_gpio", gpio, 32'h0);
    chk1("arst_irq", timer_irq, 1'b0);
    chk1("arst_tohost_valid", tohost_valid, 1'b0);
    chk("arst_tohost_data", tohost_data, 32'h0);
    chk1("arst_err", err, 1'b0);
    chk("arst_err_addr", err_addr, 32'h0);
    @(negedge clock);
    wen = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    rd(32'h100, SIZE_WORD, 32'h11AB_3344, "ram_kept");

    // Sub-word MMIO store and unmapped load after reset
    wr(MB + 32'h0, 32'h0000_00AB, SIZE_BYTE);
    chk("sb_gpio_ignored", gpio, 32'h0);
    chk1("sb_gpio_err", err, 1'b1);
    chk("sb_gpio_err_addr", err_addr, MB);
    rd(32'h2000_0000, SIZE_WORD, 32'h0, "unmapped_zero");
    chk1("unmapped_err", err, 1'b1);
    chk("unmapped_sticky", err_addr, MB);

    // Simultaneous write and read
    do_reset();
    rd(32'h100, SIZE_WORD, 32'h11AB_3344, "pre_both");
    op(1'b1, 1'b1, 32'h108, 32'h55, SIZE_WORD);
    $display("wr+rd addr=%h data=%h rdata=%h", 32'h108, 32'h55, rdata);
    chk("both_no_read", rdata, 32'h11AB_3344);
    chk1("both_err", err, 1'b1);
    chk("both_err_addr", err_addr, 32'h108);
    rd(32'h108, SIZE_WORD, 32'h55, "both_written");

    // Timer interrupt: reset is released at a negedge with MTIME=0
    do_reset();
    wr(MB + 32'h8, 32'd20, SIZE_WORD);
    chk1("irq_first", timer_irq, 1'b0);
    for (int k = 2; k <= 24; k++) begin
      @(negedge clock);
      $display("cycle %0d irq=%0b", k, timer_irq);
      chk1("irq_ramp", timer_irq, (k >= 21));
    end
    rd(MB + 32'h4, SIZE_WORD, 32'd24, "mtime_read");
    wr(MB + 32'h4, 32'h0, SIZE_WORD);
    rd(MB + 32'h4, SIZE_WORD, 32'd26, "mtime_ro");
    wr(MB + 32'h8, 32'hFFFF_FFFF, SIZE_WORD);
    chk1("irq_hold", timer_irq, 1'b1);
    @(negedge clock);
    chk1("irq_clear", timer_irq, 1'b0);
    rd(MB + 32'h8, SIZE_WORD, 32'hFFFF_FFFF, "mtimecmp_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit RAM words, RAM base address 0x0000_0000.
REQ-002 Parameter MMIO_BASE, default 32'h1000_0000: base address of the 16-byte MMIO window.
REQ-003 clock  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 dmem_addr_i  input  32  byte address from the CPU core.
REQ-006 dmem_wdata_i  input  32  store data, unshifted, taken from rs2 low bits.
REQ-007 dmem_wen_i / dmem_ren_i  input  1 each  write and read strobes.
REQ-008 dmem_size_i  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 dmem_rdata_o  output  32  registered full read word; the core performs lane select and extension.
REQ-010 gpio_o  output  32  GPIO register value.
REQ-011 timer_irq_o  output  1  timer compare interrupt level.
REQ-012 tohost_valid_o / tohost_data_o  output  1/32  test-exit mailbox pulse and data.
REQ-013 err_o / err_addr_o  output  1/32  sticky access-error flag and the address of the first faulting access.

Function
REQ-014 Decode: RAM hit when addr < 4*DEPTH_WORDS; MMIO hit when addr[31:4]==MMIO_BASE[31:4]; any other address is unmapped.
REQ-015 Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is suppressed (no write, no read-register update).
REQ-016 RAM byte enables:
- byte access: 4'b0001 << addr[1:0]
- half access: 4'b0011 << {addr[1],1'b0}
- word access: 4'b1111
REQ-017 RAM store data lane replication: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata. Only enabled bytes are written at the clock edge while dmem_wen_i is high.
REQ-018 Read latency is 1 cycle: when dmem_ren_i is high at edge N, dmem_rdata_o holds the addressed aligned word after edge N. dmem_rdata_o keeps its value until the next accepted read.
REQ-019 A read to an unmapped address loads 0 into dmem_rdata_o. A write to an unmapped address is ignored.
REQ-020 MMIO registers (word access only):
- +0x0 GPIO: read/write.
- +0x4 MTIME: read-only, 32-bit free-running counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
- +0x8 MTIMECMP: read/write.
- +0xC TOHOST: write-only, reads as 0.
REQ-021 An MMIO access with size != word is ignored. A read in that case loads 0.
REQ-022 A write to MMIO +0x4 is ignored.
REQ-023 A write to TOHOST sets tohost_valid_o high for exactly the following cycle, with tohost_data_o = wdata. tohost_data_o holds that value afterwards.
REQ-024 timer_irq_o = (MTIME >= MTIMECMP), unsigned compare, registered. It updates one cycle after either operand changes.
REQ-025 Both wen and ren high in the same cycle: the write is performed, the read is skipped, and this counts as an error.
REQ-026 Error events are misalignment (REQ-015), unmapped access, sub-word MMIO access, or wen&ren. On the first error, err_o is set and err_addr_o captures the address. Later errors change neither output until reset.

Reset
REQ-027 On reset assertion, immediately: dmem_rdata_o=0, gpio_o=0, MTIME=0, MTIMECMP=32'hFFFF_FFFF, timer_irq_o=0, tohost_valid_o=0, tohost_data_o=0, err_o=0, err_addr_o=0.
REQ-028 RAM contents are not reset. An access in flight when reset asserts is discarded.

Structure
REQ-029 The shared package riscv_pkg holds the size encodings (SIZE_BYTE/HALF/WORD) and the MMIO offset constants (MMIO_GPIO, MMIO_MTIME, MMIO_MTIMECMP, MMIO_TOHOST).
REQ-030 The RAM is one sub-module, riscv_dmem_ram: a byte-enabled, synchronous-write, synchronous-read array of DEPTH_WORDS x 32. The decode, MMIO and error logic stay in riscv_dmem_ctrl.

Verification
REQ-031 Byte-store lane test. Stimulus: SW 0x11223344 @0x100, then SB wdata=0xAB @0x102, then LW @0x100. Required: rdata=0x11AB3344 one cycle after the read strobe.
REQ-032 Half-store and misalignment test.
- SH 0xBEEF @0x106, then LW @0x104: required rdata[31:16]=0xBEEF.
- LH @0x103: required no rdata change, err_o=1, err_addr_o=0x103.
REQ-033 Timer IRQ test. Stimulus: write MTIMECMP=20 at cycle 0 after reset. Required: timer_irq_o=0 while MTIME<20 and =1 the cycle after MTIME reaches 20. Then write MTIMECMP=0xFFFF_FFFF: required timer_irq_o=0 one cycle later.
REQ-034 TOHOST test. Stimulus: SW 0x1 to MMIO_BASE+0xC. Required: tohost_valid_o high for exactly one cycle, tohost_data_o=0x1. Also, SB to MMIO_BASE+0x0 leaves gpio_o unchanged and sets err_o.
REQ-035 Unmapped and reset test.
- LW @0x2000_0000: required rdata=0, err_o=1.
- Assert reset mid-stream with a write pending: required all outputs at REQ-027 values immediately and earlier RAM data still readable after release.
